// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB completer with a bank of 32-bit registers, wait states and optional error reporting (macro APB_SLVERR_EN)
module apb_slave_regfile #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B2_0001
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam int          IDX_W     = $clog2(NUM_REGS);
  localparam logic [31:0] WIN_BYTES = 32'(NUM_REGS * 4);

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic               r_write;
  logic               r_hit;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_wdata;
  logic [31:0]        r_regs [NUM_REGS];

  logic [31:0]        w_off;
  logic               w_hit;
  logic [IDX_W-1:0]   w_idx;
  logic               w_done;
  logic [31:0]        w_rd_word;

  // Address decode of the live bus address, used only when the setup phase is latched
  always_comb begin
    w_off = paddr - BASE_ADDR;
    w_hit = (w_off < WIN_BYTES) && (paddr[1:0] == 2'b00);
    w_idx = w_off[IDX_W+1:2];
  end

  // Transfer FSM: latch setup fields, count wait states, commit writes on the completing edge
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_hit   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (psel && !penable) begin
            r_state <= ST_ACCESS;
            r_write <= pwrite;
            r_hit   <= w_hit;
            r_idx   <= w_idx;
            r_wdata <= pwdata;
            r_cnt   <= 4'(WAIT_STATES);
          end
        end
        ST_ACCESS: begin
          if (psel && penable) begin
            if (r_cnt == 4'd0) begin
              // Register 0 is the read-only ID word; writes to it or outside the window are dropped
              if (r_write && r_hit && (r_idx != '0)) begin
                r_regs[r_idx] <= r_wdata;
              end
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end else begin
            // Master left the access phase early: abandon the transfer without side effects
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Completion and response data derived from state and latched fields only
  always_comb begin
    w_done    = (r_state == ST_ACCESS) && psel && penable && (r_cnt == 4'd0);
    w_rd_word = (r_idx == '0) ? ID_VALUE : r_regs[r_idx];
    pready    = w_done;
    prdata    = (w_done && !r_write && r_hit) ? w_rd_word : 32'd0;
`ifdef APB_SLVERR_EN
    pslverr   = w_done && (!r_hit || (r_write && (r_idx == '0)));
`else
    pslverr   = 1'b0;
`endif
  end

endmodule
